// File: rtl/merge_sched_if.sv
// merge_sched_if: handshake bundle between a merge-router join point and its
// sequencing controller.
//   cfg_valid/cfg_ready/cfg_mask/cfg_sel/cfg_len : job descriptor channel
//   in_valid/in_ready                            : per-port input FIFO status / pop
//   out_valid/out_ready                          : per-port merged-flit handshake
// master = descriptor source and stream environment, slave = merge_sched.
interface merge_sched_if #(
  parameter int NUM_IN = 5,
  parameter int CNT_W  = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [NUM_IN-1:0] cfg_mask;
  logic [NUM_IN-1:0] cfg_sel;
  logic [CNT_W-1:0]  cfg_len;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic [NUM_IN-1:0] out_valid;
  logic [NUM_IN-1:0] out_ready;

  modport master (
    output cfg_valid, cfg_mask, cfg_sel, cfg_len, in_valid, out_ready,
    input  cfg_ready, in_ready, out_valid
  );

  modport slave (
    input  cfg_valid, cfg_mask, cfg_sel, cfg_len, in_valid, out_ready,
    output cfg_ready, in_ready, out_valid
  );
endinterface

// File: rtl/merge_sched.sv
// merge_sched: sequencing controller for one merge-router join point.
// Accepts a descriptor (input mask, one-hot output select, flit count), then
// gates the join of the masked inputs so exactly len merged flits pass,
// popping all masked inputs in lock-step. Pulses done on completion and
// flags a partial join that stalls for TIMEOUT cycles.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : merge_sched_if slave (descriptor + stream handshakes)
//   abort        : synchronous job cancel
//   busy         : high while a job runs
//   done         : one-cycle pulse at job completion
//   err_cfg      : one-cycle pulse when a descriptor is rejected
//   err_timeout  : sticky watchdog error, cleared by abort
//   flit_cnt     : merged flits completed in the current or last job
module merge_sched #(
  parameter int NUM_IN  = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  merge_sched_if.slave     bus,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_timeout,
  output logic [CNT_W-1:0] flit_cnt
);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_IN-1:0]  IN_ONE    = NUM_IN'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IN-1:0]  mask_q, mask_d;
  logic [NUM_IN-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_cfg_q, err_cfg_d;
  logic               err_to_q, err_to_d;

  logic run, all_v, rdy, any_mv, fire, partial, cfg_ok;

  function automatic logic is_onehot(input logic [NUM_IN-1:0] v);
    return (v != '0) && ((v & (v - IN_ONE)) == '0);
  endfunction

  // Join logic: zero-latency; out_valid never looks at out_ready so the
  // downstream ready path cannot loop back through out_valid.
  always_comb begin
    run     = (state_q == S_RUN);
    all_v   = &(~mask_q | bus.in_valid);
    rdy     = |(sel_q & bus.out_ready);
    any_mv  = |(mask_q & bus.in_valid);
    partial = any_mv & ~all_v;
    fire    = run & all_v & rdy & ~abort;
    cfg_ok  = (bus.cfg_mask != '0) && is_onehot(bus.cfg_sel) && (bus.cfg_len != '0);
    bus.out_valid = run ? (sel_q & {NUM_IN{all_v}}) : '0;
    bus.in_ready  = mask_q & {NUM_IN{fire}};
  end

  // Status outputs are decoded straight from flops.
  always_comb begin
    bus.cfg_ready = (state_q == S_IDLE);
    busy          = (state_q == S_RUN);
    done          = (state_q == S_DONE);
    err_cfg       = err_cfg_q;
    err_timeout   = err_to_q;
    flit_cnt      = cnt_q;
  end

  // Next-state: descriptor check, flit counting, watchdog and abort.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    err_to_d  = err_to_q;
    err_cfg_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort outranks a descriptor offered in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (bus.cfg_valid) begin
          if (cfg_ok) begin
            mask_d  = bus.cfg_mask;
            sel_d   = bus.cfg_sel;
            len_d   = bus.cfg_len;
            cnt_d   = '0;
            stall_d = '0;
            state_d = S_RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          stall_d  = '0;
          err_to_d = 1'b0;
        end else if (fire) begin
          // fire always beats the stall limit
          cnt_d   = cnt_q + CNT_ONE;
          stall_d = '0;
          if (cnt_q == len_q - CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else if (partial) begin
          stall_d = stall_q + STALL_ONE;
          if (stall_q == STALL_MAX - STALL_ONE) begin
            err_to_d = 1'b1;
            state_d  = S_ERR;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          // no masked input valid, or full join held by backpressure
          stall_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) begin
          stall_d  = '0;
          err_to_d = 1'b0;
        end else begin
          stall_d = stall_q;
        end
      end
      S_ERR: begin
        if (abort) begin
          state_d  = S_IDLE;
          stall_d  = '0;
          err_to_d = 1'b0;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      sel_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      stall_q   <= '0;
      err_cfg_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      err_cfg_q <= err_cfg_d;
      err_to_q  <= err_to_d;
    end
  end
endmodule

// File: tb/tb_merge_sched.sv
// tb_merge_sched: self-checking bench for merge_sched. Expected pop patterns
// and expected job lengths are queued when stimulus is driven and popped when
// the DUT produces the matching output.
module tb_merge_sched;
  localparam int NUM_IN  = 5;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic             busy, done, err_cfg, err_timeout;
  logic [CNT_W-1:0] flit_cnt;

  merge_sched_if #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus ();

  merge_sched #(.NUM_IN(NUM_IN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort(abort),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NUM_IN-1:0] exp_rdy_q[$];
  int                exp_len_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [4:0] m, input logic [4:0] s, input logic [15:0] l);
    bus.cfg_valid = 1'b1;
    bus.cfg_mask  = m;
    bus.cfg_sel   = s;
    bus.cfg_len   = l;
    exp_len_q.push_back(int'(l));
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_mask = '0; bus.cfg_sel = '0; bus.cfg_len = '0;
    bus.in_valid = 5'b11111; bus.out_ready = 5'b11111;
    step(); step();
    rst = 1'b0;
    #3;
    n_checks++;
    if ({bus.cfg_ready, busy, done, err_cfg, err_timeout} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 10000", {bus.cfg_ready, busy, done, err_cfg, err_timeout});
    end
    n_checks++;
    if (flit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flit_cnt: got %0d expected 0", flit_cnt); end
    n_checks++;
    if ({bus.in_ready, bus.out_valid} !== 10'd0) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 0", {bus.in_ready, bus.out_valid});
    end
    step();
  endtask

  task automatic test_basic();
    logic [NUM_IN-1:0] e;
    int el;
    bus.in_valid = 5'b01100; bus.out_ready = 5'b10000;
    start_job(5'b01100, 5'b10000, 16'd3);
    for (int i = 0; i < 3; i++) begin
      exp_rdy_q.push_back(5'b01100);
      #3;
      e = exp_rdy_q.pop_front();
      n_checks++;
      if (bus.in_ready !== e) begin n_fail++; $display("FAIL basic_in_ready[%0d]: got %b expected %b", i, bus.in_ready, e); end
      n_checks++;
      if ({busy, bus.out_valid} !== 6'b110000) begin
        n_fail++; $display("FAIL basic_out_valid[%0d]: got %b expected 110000", i, {busy, bus.out_valid});
      end
      step();
    end
    #3;
    el = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    n_checks++;
    if ({done, bus.cfg_ready, bus.in_ready} !== 7'b1000000) begin
      n_fail++; $display("FAIL basic_done: got %b expected 1000000", {done, bus.cfg_ready, bus.in_ready});
    end
    n_checks++;
    if (int'(flit_cnt) !== el) begin n_fail++; $display("FAIL basic_flit_cnt: got %0d expected %0d", flit_cnt, el); end
    step(); #3;
    n_checks++;
    if ({done, bus.cfg_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_idle: got %b expected 01", {done, bus.cfg_ready}); end
    step();
  endtask

  task automatic test_skew();
    logic [NUM_IN-1:0] e;
    int el;
    bus.in_valid = 5'b00100; bus.out_ready = 5'b10000;
    start_job(5'b01100, 5'b10000, 16'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.in_valid = 5'b01100;
      exp_rdy_q.push_back((i < 2) ? 5'b00000 : 5'b01100);
      #3;
      e = exp_rdy_q.pop_front();
      n_checks++;
      if (bus.in_ready !== e) begin n_fail++; $display("FAIL skew_in_ready[%0d]: got %b expected %b", i, bus.in_ready, e); end
      n_checks++;
      if (bus.out_valid !== ((i < 2) ? 5'b00000 : 5'b10000)) begin
        n_fail++; $display("FAIL skew_out_valid[%0d]: got %b", i, bus.out_valid);
      end
      step();
    end
    #3;
    el = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    n_checks++;
    if ({done, err_timeout} !== 2'b10 || int'(flit_cnt) !== el) begin
      n_fail++; $display("FAIL skew_done: got done/err %b cnt %0d expected 10 cnt %0d", {done, err_timeout}, flit_cnt, el);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [NUM_IN-1:0] e;
    int el;
    bus.in_valid = 5'b01100; bus.out_ready = 5'b10000;
    start_job(5'b01100, 5'b10000, 16'd2);
    // ready pattern 1, then 0 for longer than TIMEOUT, then 1
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i == 0 || i == 11) ? 5'b10000 : 5'b00000;
      exp_rdy_q.push_back((i == 0 || i == 11) ? 5'b01100 : 5'b00000);
      #3;
      e = exp_rdy_q.pop_front();
      n_checks++;
      if (bus.in_ready !== e || bus.out_valid !== 5'b10000 || err_timeout !== 1'b0) begin
        n_fail++; $display("FAIL bp_cycle[%0d]: got rdy %b ov %b err %b expected rdy %b ov 10000 err 0",
                           i, bus.in_ready, bus.out_valid, err_timeout, e);
      end
      step();
    end
    #3;
    el = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    n_checks++;
    if (done !== 1'b1 || int'(flit_cnt) !== el) begin
      n_fail++; $display("FAIL bp_done: got done %b cnt %0d expected 1 cnt %0d", done, flit_cnt, el);
    end
    step();
  endtask

  task automatic test_timeout();
    bus.in_valid = 5'b00001; bus.out_ready = 5'b11111;
    start_job(5'b00011, 5'b00001, 16'd4);
    for (int i = 0; i < TIMEOUT; i++) begin
      #3;
      n_checks++;
      if ({busy, err_timeout, bus.in_ready} !== 7'b1000000) begin
        n_fail++; $display("FAIL to_stall[%0d]: got %b expected 1000000", i, {busy, err_timeout, bus.in_ready});
      end
      step();
    end
    #3;
    n_checks++;
    if ({busy, err_timeout, bus.cfg_ready, bus.out_valid} !== 8'b01000000) begin
      n_fail++; $display("FAIL to_err: got %b expected 01000000", {busy, err_timeout, bus.cfg_ready, bus.out_valid});
    end
    step(); step();
    abort = 1'b1;
    #3;
    n_checks++;
    if ({err_timeout, bus.in_ready} !== 6'b100000) begin
      n_fail++; $display("FAIL to_held: got %b expected 100000", {err_timeout, bus.in_ready});
    end
    step();
    abort = 1'b0;
    #3;
    n_checks++;
    if ({bus.cfg_ready, err_timeout, busy} !== 3'b100) begin
      n_fail++; $display("FAIL to_abort: got %b expected 100", {bus.cfg_ready, err_timeout, busy});
    end
    exp_len_q.delete();
    step();
  endtask

  task automatic test_bad_cfg();
    logic [4:0]  m_tab[3] = '{5'b00000, 5'b00011, 5'b00011};
    logic [4:0]  s_tab[3] = '{5'b10000, 5'b00110, 5'b10000};
    logic [15:0] l_tab[3] = '{16'd3, 16'd3, 16'd0};
    bus.in_valid = 5'b11111; bus.out_ready = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      bus.cfg_valid = 1'b1; bus.cfg_mask = m_tab[i]; bus.cfg_sel = s_tab[i]; bus.cfg_len = l_tab[i];
      step();
      bus.cfg_valid = 1'b0;
      #3;
      n_checks++;
      if ({err_cfg, busy, bus.cfg_ready, bus.in_ready} !== 8'b10100000) begin
        n_fail++; $display("FAIL badcfg_pulse[%0d]: got %b expected 10100000", i, {err_cfg, busy, bus.cfg_ready, bus.in_ready});
      end
      step(); #3;
      n_checks++;
      if (err_cfg !== 1'b0) begin n_fail++; $display("FAIL badcfg_clear[%0d]: got %b expected 0", i, err_cfg); end
      step();
    end
    // abort outranks a valid descriptor in IDLE
    bus.cfg_valid = 1'b1; bus.cfg_mask = 5'b00011; bus.cfg_sel = 5'b00001; bus.cfg_len = 16'd2;
    abort = 1'b1;
    step();
    bus.cfg_valid = 1'b0; abort = 1'b0;
    #3;
    n_checks++;
    if ({busy, err_cfg, bus.cfg_ready, bus.in_ready} !== 8'b00100000) begin
      n_fail++; $display("FAIL abort_idle: got %b expected 00100000", {busy, err_cfg, bus.cfg_ready, bus.in_ready});
    end
    step();
  endtask

  task automatic test_async_reset();
    int el;
    bus.in_valid = 5'b01100; bus.out_ready = 5'b10000;
    start_job(5'b01100, 5'b10000, 16'd5);
    step(); step();
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, bus.cfg_ready, bus.in_ready, bus.out_valid} !== 12'b010000000000 || flit_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_rst: got %b cnt %0d expected 010000000000 cnt 0",
                         {busy, bus.cfg_ready, bus.in_ready, bus.out_valid}, flit_cnt);
    end
    #1;
    rst = 1'b0;
    exp_len_q.delete();
    step();
    start_job(5'b01100, 5'b10000, 16'd2);
    #3;
    n_checks++;
    if (flit_cnt !== 16'd0 || bus.in_ready !== 5'b01100) begin
      n_fail++; $display("FAIL after_rst_first: got cnt %0d rdy %b expected 0 01100", flit_cnt, bus.in_ready);
    end
    step(); #3;
    n_checks++;
    if (flit_cnt !== 16'd1) begin n_fail++; $display("FAIL after_rst_cnt: got %0d expected 1", flit_cnt); end
    step(); #3;
    el = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
    n_checks++;
    if (done !== 1'b1 || int'(flit_cnt) !== el) begin
      n_fail++; $display("FAIL after_rst_done: got done %b cnt %0d expected 1 cnt %0d", done, flit_cnt, el);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_timeout();
    test_bad_cfg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
